// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: source-side and FIFO-side handshake bundle for the round-robin FIFO write arbiter
interface fifo_wr_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 16,
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       src_last;
  logic [N_SRC-1:0]       src_valid;
  logic [N_SRC-1:0]       src_ready;
  logic [WIDTH-1:0]       fifo_wr_data;
  logic                   fifo_wr_last;
  logic                   fifo_wr_ena;
  logic                   fifo_wr_full;
  logic                   busy;
  logic [SEL_W-1:0]       cur_src;
  logic                   pkt_done;
  modport master (
    output src_data, src_last, src_valid, fifo_wr_full,
    input  src_ready, fifo_wr_data, fifo_wr_last, fifo_wr_ena, busy, cur_src, pkt_done
  );
  modport slave (
    input  src_data, src_last, src_valid, fifo_wr_full,
    output src_ready, fifo_wr_data, fifo_wr_last, fifo_wr_ena, busy, cur_src, pkt_done
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among N_SRC sources; FIFO_ARB_PKT_LOCK_EN holds grants for whole packets
module fifo_wr_arbiter #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state_q;
  logic [SEL_W-1:0] sel_q, sel_d, rr_ptr_q, rr_ptr_d, idx;
  logic             pkt_done_q, busy_q, xfer, rel;
  // next grant: first valid source at or after rr_ptr, wrapping modulo N_SRC
  always_comb begin
    sel_d = rr_ptr_q;
    idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = SEL_W'((int'(rr_ptr_q) + k) % N_SRC);
      if (bus.src_valid[idx]) sel_d = idx;
    end
  end
  // transfer, release and pointer advance for the current grant
  always_comb begin
    xfer     = (state_q == GRANT) & bus.src_valid[sel_q] & ~bus.fifo_wr_full;
`ifdef FIFO_ARB_PKT_LOCK_EN
    rel      = xfer & bus.src_last[sel_q];
`else
    rel      = xfer;
`endif
    rr_ptr_d = (sel_q == SEL_W'(N_SRC - 1)) ? '0 : sel_q + 1'b1;
  end
  // steer granted source onto the FIFO port; full stalls in the same cycle
  always_comb begin
    bus.src_ready        = '0;
    bus.src_ready[sel_q] = (state_q == GRANT) & ~bus.fifo_wr_full;
  end
  assign bus.fifo_wr_data = bus.src_data[sel_q*WIDTH +: WIDTH];
  assign bus.fifo_wr_last = bus.src_last[sel_q];
  assign bus.fifo_wr_ena  = xfer;
  assign bus.busy         = busy_q;
  assign bus.cur_src      = sel_q;
  assign bus.pkt_done     = pkt_done_q;
  // grant FSM with registered busy and release pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      pkt_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (|bus.src_valid) begin
          sel_q   <= sel_d;
          state_q <= GRANT;
          busy_q  <= 1'b1;
        end
      end else if (rel) begin
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        rr_ptr_q   <= rr_ptr_d;
        pkt_done_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scoreboard bench for fifo_wr_arbiter (either FIFO_ARB_PKT_LOCK_EN build)
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 16;
`ifdef FIFO_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_wr_arbiter_if #(.N_SRC(N), .WIDTH(W)) bus ();
  fifo_wr_arbiter #(.N_SRC(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [W:0]   src_q [N][$];
  logic [W+2:0] exp_q [$];
  int checks = 0, errors = 0, cyc = 0, last_wr = -100, min_gap = 1000, t0 = 0;
  function automatic logic [W+2:0] mk(int s, logic l, logic [W-1:0] d);
    return {2'(s), l, d};
  endfunction
  function automatic bit pending();
    bit p = exp_q.size() != 0;
    for (int i = 0; i < N; i++) p |= src_q[i].size() != 0;
    return p;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(int s, logic l, logic [W-1:0] d);
    src_q[s].push_back({l, d});
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.src_valid[i] = src_q[i].size() != 0;
      if (src_q[i].size() != 0) {bus.src_last[i], bus.src_data[i*W +: W]} = src_q[i][0];
    end
  endtask
  task automatic cycle();
    logic [N-1:0] acc;
    logic [W+2:0] e;
    @(negedge clk);
    acc = bus.src_ready & bus.src_valid;
    if (bus.fifo_wr_full) chk("ena_while_full", 32'(bus.fifo_wr_ena), 32'(0));
    chk("ena_vs_accept", 32'(bus.fifo_wr_ena), 32'(|acc));
    chk("ready_mask", 32'(bus.src_ready & ~(N'(1) << bus.cur_src)), 32'(0));
    if (bus.fifo_wr_ena) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(exp_q.size()), 32'(1));
      else begin
        e = exp_q.pop_front();
        chk("wr_word", 32'({bus.cur_src, bus.fifo_wr_last, bus.fifo_wr_data}), 32'(e));
      end
      if (cyc - last_wr < min_gap) min_gap = cyc - last_wr;
      last_wr = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(src_q[i].pop_front());
    drive();
  endtask
  task automatic drain(int max);
    int n = 0;
    while ((bus.busy || pending()) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(n < max), 32'(1));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.src_data = '0;
    bus.src_last = '0;
    bus.src_valid = '1;
    bus.fifo_wr_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.src_ready), 32'(0));
    chk("rst_ena", 32'(bus.fifo_wr_ena), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_cur_src", 32'(bus.cur_src), 32'(0));
    chk("rst_pkt_done", 32'(bus.pkt_done), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.src_ready), 32'(0));
    chk("post_rst_ena", 32'(bus.fifo_wr_ena), 32'(0));
    chk("post_rst_busy", 32'(bus.busy), 32'(0));
    chk("post_rst_cur_src", 32'(bus.cur_src), 32'(0));
    bus.src_valid = '0;
    @(posedge clk);
    #1;
    push(2, 1'b0, 16'hA1); push(2, 1'b0, 16'hA2); push(2, 1'b1, 16'hA3);
    exp_q.push_back(mk(2, 1'b0, 16'hA1));
    exp_q.push_back(mk(2, 1'b0, 16'hA2));
    exp_q.push_back(mk(2, 1'b1, 16'hA3));
    drive();
    t0 = cyc;
    cycle();
    chk("grant_busy", 32'(bus.busy), 32'(1));
    chk("grant_cur_src", 32'(bus.cur_src), 32'(2));
    chk("grant_ready", 32'(bus.src_ready), 32'(4));
    chk("grant_ena", 32'(bus.fifo_wr_ena), 32'(1));
    drain(30);
    chk("single_last_wr_cycle", 32'(last_wr), 32'(t0 + (LOCK ? 3 : 5)));
    chk("single_pkt_done", 32'(bus.pkt_done), 32'(1));
    chk("single_busy_low", 32'(bus.busy), 32'(0));
    cycle();
    chk("single_pkt_done_pulse", 32'(bus.pkt_done), 32'(0));
    push(1, 1'b0, 16'hB1); push(1, 1'b0, 16'hB2); push(1, 1'b1, 16'hB3);
    exp_q.push_back(mk(1, 1'b0, 16'hB1));
    drive();
    cycle();
    cycle();
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'(0));
    chk("midrst_ready", 32'(bus.src_ready), 32'(0));
    chk("midrst_ena", 32'(bus.fifo_wr_ena), 32'(0));
    chk("midrst_cur_src", 32'(bus.cur_src), 32'(0));
    chk("midrst_exp_empty", 32'(exp_q.size()), 32'(0));
    src_q[1].delete();
    drive();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++)
        for (int w = 0; w < 2; w++) push(s, w == 1, 16'(16'hC000 | (s << 8) | (p << 4) | w));
    if (LOCK) begin
      for (int p = 0; p < 2; p++)
        for (int s = 0; s < N; s++)
          for (int w = 0; w < 2; w++) exp_q.push_back(mk(s, w == 1, 16'(16'hC000 | (s << 8) | (p << 4) | w)));
    end else begin
      for (int k = 0; k < 4; k++)
        for (int s = 0; s < N; s++) exp_q.push_back(mk(s, k[0], 16'(16'hC000 | (s << 8) | ((k >> 1) << 4) | (k & 1))));
    end
    min_gap = 1000;
    last_wr = -100;
    drive();
    drain(200);
    chk("rr_min_gap", 32'(min_gap), 32'(LOCK ? 1 : 2));
    for (int w = 0; w < 4; w++) push(0, w == 3, 16'(16'hD0 + w));
    for (int w = 0; w < 4; w++) exp_q.push_back(mk(0, w == 3, 16'(16'hD0 + w)));
    drive();
    cycle();
    cycle();
    bus.fifo_wr_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ena", 32'(bus.fifo_wr_ena), 32'(0));
      chk("bp_ready", 32'(bus.src_ready), 32'(0));
      cycle();
    end
    chk("bp_word_held", 32'(src_q[0].size()), 32'(3));
    bus.fifo_wr_full = 1'b0;
    drain(60);
    push(1, 1'b1, 16'hE1);
    exp_q.push_back(mk(1, 1'b1, 16'hE1));
    drive();
    drain(20);
    push(1, 1'b1, 16'hF1);
    push(3, 1'b1, 16'hF3);
    exp_q.push_back(mk(3, 1'b1, 16'hF3));
    exp_q.push_back(mk(1, 1'b1, 16'hF1));
    drive();
    cycle();
    chk("skip_first_grant", 32'(bus.cur_src), 32'(3));
    drain(20);
    chk("final_exp_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
